// File: rtl/pipe_fetch_stage.sv
// pipe_fetch_stage: instruction-fetch stage and IF/RF pipeline register.
// Owns the PC and resolves J/JAL in IF. Inserts NOP bubbles after BEQ/BNE
// (two), JR and LW (one). A redirect from RF (JR) or EX (BEQ/BNE) is taken
// on the last bubble cycle.
// Ports:
//   clk, reset         clock, asynchronous active-high reset
//   instr_mem          instruction word read combinationally at pc_out
//   stall              freeze every register
//   redirect_valid     later stage resolved a control transfer this cycle
//   redirect_target    new PC when the redirect is honoured
//   pc_out             current fetch address
//   instr_rf           IF/RF instruction register (0 for a bubble)
//   pc_plus4_rf        PC+4 of instr_rf (JAL link value)
//   valid_rf           instr_rf holds a real fetched instruction
//   bubble             stage is in WAIT (combinational from state)
module pipe_fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] instr_mem,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    output logic [31:0] pc_out,
    output logic [31:0] instr_rf,
    output logic [31:0] pc_plus4_rf,
    output logic        valid_rf,
    output logic        bubble
);

    localparam int unsigned XLEN = 32;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] FN_JR    = 6'h08;

    localparam logic [0:0] ST_RUN  = 1'b0;
    localparam logic [0:0] ST_WAIT = 1'b1;

    localparam logic [1:0] CNT_BRANCH = 2'd2;
    localparam logic [1:0] CNT_ONE    = 2'd1;

    logic [0:0]      state, state_nxt;
    logic [1:0]      cnt, cnt_nxt;
    logic [XLEN-1:0] pc_nxt, instr_nxt, pc_plus4_rf_nxt;
    logic            valid_nxt;

    logic [5:0]      opcode;
    logic [5:0]      funct;
    logic            is_jump;
    logic            is_branch;
    logic            is_single_wait;
    logic [XLEN-1:0] pc_plus4;
    logic [XLEN-1:0] jump_target;

    // IF-stage decode of the word being fetched
    always_comb begin
        opcode         = instr_mem[31:26];
        funct          = instr_mem[5:0];
        is_jump        = (opcode == OP_J) || (opcode == OP_JAL);
        is_branch      = (opcode == OP_BEQ) || (opcode == OP_BNE);
        is_single_wait = ((opcode == OP_RTYPE) && (funct == FN_JR)) || (opcode == OP_LW);
        pc_plus4       = pc_out + XLEN'(4);
        jump_target    = {pc_plus4[31:28], instr_mem[25:0], 2'b00};
    end

    // Next-state and next-register values
    always_comb begin
        state_nxt       = state;
        cnt_nxt         = cnt;
        pc_nxt          = pc_out;
        instr_nxt       = instr_rf;
        pc_plus4_rf_nxt = pc_plus4_rf;
        valid_nxt       = valid_rf;

        if (!stall) begin
            case (state)
                ST_RUN: begin
                    instr_nxt       = instr_mem;
                    pc_plus4_rf_nxt = pc_plus4;
                    valid_nxt       = 1'b1;
                    pc_nxt          = is_jump ? jump_target : pc_plus4;
                    if (is_branch) begin
                        cnt_nxt   = CNT_BRANCH;
                        state_nxt = ST_WAIT;
                    end else if (is_single_wait) begin
                        cnt_nxt   = CNT_ONE;
                        state_nxt = ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    instr_nxt = '0;
                    valid_nxt = 1'b0;
                    cnt_nxt   = cnt - 2'd1;
                    // Only the final bubble may take the resolved redirect
                    if (cnt == CNT_ONE) begin
                        state_nxt = ST_RUN;
                        if (redirect_valid) begin
                            pc_nxt = redirect_target;
                        end
                    end
                end
                default: begin
                    state_nxt = ST_RUN;
                    cnt_nxt   = '0;
                end
            endcase
        end
    end

    // State and pipeline registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= ST_RUN;
            cnt         <= '0;
            pc_out      <= RESET_PC;
            instr_rf    <= '0;
            pc_plus4_rf <= '0;
            valid_rf    <= 1'b0;
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            pc_out      <= pc_nxt;
            instr_rf    <= instr_nxt;
            pc_plus4_rf <= pc_plus4_rf_nxt;
            valid_rf    <= valid_nxt;
        end
    end

    assign bubble = (state == ST_WAIT);

endmodule

// File: tb/tb_pipe_fetch_stage.sv
// tb_pipe_fetch_stage: scoreboard bench for pipe_fetch_stage.
// A transaction-level model predicts the IF/RF contents after every edge;
// a negedge monitor pops the prediction and compares it with the DUT.
module tb_pipe_fetch_stage;

    localparam logic [31:0] RST_PC = 32'h0000_0100;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] pcp4;
        logic        valid;
        logic        bub;
    } exp_t;

    logic        clk;
    logic        reset;
    logic [31:0] instr_mem;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic [31:0] pc_out;
    logic [31:0] instr_rf;
    logic [31:0] pc_plus4_rf;
    logic        valid_rf;
    logic        bubble;

    int checks = 0;
    int errors = 0;

    // program memory
    logic [31:0] mem [logic [31:0]];
    bit          rand_mode = 1'b0;
    int          mem_gen = 0;

    // reference model state
    exp_t        exp_q [$];
    logic [31:0] m_pc;
    logic [31:0] m_instr;
    logic [31:0] m_pcp4;
    logic        m_valid;
    int          m_pending;
    logic [31:0] m_last_pc;
    int          visits10;

    pipe_fetch_stage #(.RESET_PC(RST_PC)) dut (
        .clk(clk),
        .reset(reset),
        .instr_mem(instr_mem),
        .stall(stall),
        .redirect_valid(redirect_valid),
        .redirect_target(redirect_target),
        .pc_out(pc_out),
        .instr_rf(instr_rf),
        .pc_plus4_rf(pc_plus4_rf),
        .valid_rf(valid_rf),
        .bubble(bubble)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] filler(input logic [31:0] a);
        return {6'h00, 5'd1, 5'd2, a[11:2], 6'h20};
    endfunction

    function automatic logic [31:0] hash_word(input logic [31:0] a);
        logic [31:0] h;
        h = a * 32'h9E37_79B1;
        h = h ^ (h >> 15);
        h = h * 32'h85EB_CA6B;
        h = h ^ (h >> 13);
        case (h[2:0])
            3'd0:    return {6'h02, h[31:6]};
            3'd1:    return {6'h03, h[31:6]};
            3'd2:    return {6'h04, h[31:6]};
            3'd3:    return {6'h05, h[31:6]};
            3'd4:    return {6'h00, h[31:27], 15'd0, 6'h08};
            3'd5:    return {6'h23, h[31:6]};
            3'd6:    return {6'h00, h[31:12], 6'h20};
            default: return {6'h08, h[31:6]};
        endcase
    endfunction

    function automatic logic [31:0] fetch_word(input logic [31:0] a);
        if (rand_mode) return hash_word(a);
        if (mem.exists(a)) return mem[a];
        return filler(a);
    endfunction

    always @(pc_out or mem_gen or rand_mode) instr_mem = fetch_word(pc_out);

    // Reference model: one slot per unstalled edge. A real fetch is followed
    // by as many bubbles as its class costs; the last bubble takes a redirect.
    always @(posedge clk or posedge reset) begin
        exp_t e;
        logic [31:0] w;
        logic [5:0]  op;
        if (reset) begin
            m_pc      = RST_PC;
            m_instr   = '0;
            m_pcp4    = '0;
            m_valid   = 1'b0;
            m_pending = 0;
            m_last_pc = 32'h1;
            exp_q.delete();
        end else begin
            if (!stall) begin
                if (m_pending == 0) begin
                    w         = fetch_word(m_pc);
                    op        = w[31:26];
                    m_last_pc = m_pc;
                    if (m_pc == 32'h10) visits10++;
                    m_instr   = w;
                    m_pcp4    = m_pc + 32'd4;
                    m_valid   = 1'b1;
                    if (op == 6'h04 || op == 6'h05)
                        m_pending = 2;
                    else if ((op == 6'h00 && w[5:0] == 6'h08) || op == 6'h23)
                        m_pending = 1;
                    if (op == 6'h02 || op == 6'h03)
                        m_pc = {m_pcp4[31:28], w[25:0], 2'b00};
                    else
                        m_pc = m_pcp4;
                end else begin
                    m_instr   = '0;
                    m_valid   = 1'b0;
                    m_pending = m_pending - 1;
                    if (m_pending == 0 && redirect_valid) m_pc = redirect_target;
                end
            end
            e.pc    = m_pc;
            e.instr = m_instr;
            e.pcp4  = m_pcp4;
            e.valid = m_valid;
            e.bub   = (m_pending != 0);
            exp_q.push_back(e);
        end
    end

    // Monitor: compare DUT state with the prediction for the last edge
    always @(negedge clk) begin
        exp_t e;
        if (!reset && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (pc_out !== e.pc || instr_rf !== e.instr || pc_plus4_rf !== e.pcp4 ||
                valid_rf !== e.valid || bubble !== e.bub) begin
                errors++;
                $display("FAIL scoreboard t=%0t pc_out=%h/%h instr_rf=%h/%h pc_plus4_rf=%h/%h valid_rf=%b/%b bubble=%b/%b (got/exp)",
                         $time, pc_out, e.pc, instr_rf, e.instr, pc_plus4_rf, e.pcp4,
                         valid_rf, e.valid, bubble, e.bub);
            end
        end
    end

    task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", name, act, expv);
        end
    endtask

    task automatic check_reset_values(input string tag);
        check_val({tag, "_pc_out"}, pc_out, RST_PC);
        check_val({tag, "_instr_rf"}, instr_rf, 32'h0);
        check_val({tag, "_pc_plus4_rf"}, pc_plus4_rf, 32'h0);
        check_val({tag, "_valid_rf"}, {31'h0, valid_rf}, 32'h0);
        check_val({tag, "_bubble"}, {31'h0, bubble}, 32'h0);
    endtask

    // Redirect that the later stages would return for the directed program
    task automatic drive_directed_redirect();
        case (m_last_pc)
            32'h10: begin redirect_valid = visits10[0]; redirect_target = 32'h40; end
            32'h30: begin redirect_valid = 1'b1; redirect_target = 32'h80; end
            32'h88: begin redirect_valid = 1'b1; redirect_target = 32'h60; end
            32'h64: begin redirect_valid = 1'b1; redirect_target = 32'hFFFF_FFFC; end
            default: begin redirect_valid = 1'b0; redirect_target = 32'hDEAD_BEE0; end
        endcase
    endtask

    task automatic run_directed(input int cycles, input bit do_stall);
        int stall_left = 0;
        bit stall_done = 1'b0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            #1;
            drive_directed_redirect();
            if (do_stall && !stall_done && m_last_pc == 32'h88 && m_pending == 1) begin
                stall_done = 1'b1;
                stall_left = 3;
            end
            if (stall_left > 0) begin
                stall = 1'b1;
                stall_left--;
            end else begin
                stall = 1'b0;
            end
        end
        stall = 1'b0;
    endtask

    initial begin
        bit found;
        reset           = 1'b0;
        stall           = 1'b0;
        redirect_valid  = 1'b0;
        redirect_target = '0;
        visits10        = 0;

        // directed program
        mem[32'h110] = {6'h02, 26'h4};                      // J 0x10
        mem[32'h010] = {6'h04, 5'd1, 5'd2, 16'h0003};       // BEQ
        mem[32'h018] = {6'h02, 26'h8};                      // J 0x20
        mem[32'h020] = {6'h03, 26'h10};                     // JAL 0x40
        mem[32'h044] = {6'h02, 26'hC};                      // J 0x30
        mem[32'h030] = {6'h00, 5'd31, 15'd0, 6'h08};        // JR
        mem[32'h080] = {6'h23, 5'd0, 5'd1, 16'h0};          // LW
        mem[32'h088] = {6'h04, 5'd3, 5'd4, 16'h0010};       // BEQ
        mem[32'h064] = {6'h05, 5'd5, 5'd6, 16'h0020};       // BNE
        mem_gen++;

        #1 reset = 1'b1;
        #2 check_reset_values("reset_init");
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        run_directed(130, 1'b1);

        // Reset in the middle of a wait with a redirect pending
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            @(posedge clk);
            found = (m_pending > 0);
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL wait_entry got=none exp=WAIT");
        end
        #2;
        redirect_valid  = 1'b1;
        redirect_target = 32'h0000_0200;
        reset           = 1'b1;
        #1 check_reset_values("reset_mid_wait");
        @(negedge clk);
        #1 reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
        end
        redirect_valid = 1'b0;
        run_directed(60, 1'b0);

        // Randomized program and control inputs
        @(negedge clk);
        reset = 1'b1;
        mem.delete();
        rand_mode = 1'b1;
        mem_gen++;
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            #1;
            stall           = ($urandom_range(0, 4) == 0);
            redirect_valid  = 1'($urandom_range(0, 1));
            redirect_target = ($urandom_range(0, 3) == 0) ? 32'($urandom)
                                                           : (32'($urandom) & 32'hFFFF_FFFC);
        end
        stall = 1'b0;
        @(negedge clk);
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipe_fetch_stage.md
# pipe_fetch_stage

Instruction-fetch stage and IF/RF pipeline register for the 5-stage MIPS pipeline CPU. Owns the PC, drives the instruction-memory address, and resolves J/JAL in IF. Inserts NOP bubbles after BEQ, BNE, JR and LW, and applies the redirect returned by the RF stage (JR) or the EX stage (BEQ/BNE). Its outputs feed the instruction decoder and the control LUT in the RF stage directly.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.

Ports:
- clk  in  1  pipeline clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- instr_mem  in  32  instruction read combinationally from memory at pc_out.
- stall  in  1  external freeze: hold PC, instr_rf, state and counter.
- redirect_valid  in  1  later stage has resolved a control transfer this cycle.
- redirect_target  in  32  new PC when redirect_valid is honoured.
- pc_out  out  32  current fetch address.
- instr_rf  out  32  IF/RF instruction register; 32'h0 when it holds a bubble.
- pc_plus4_rf  out  32  PC+4 of the instruction in instr_rf, used as the JAL link value.
- valid_rf  out  1  1 = instr_rf holds a real fetched instruction.
- bubble  out  1  1 while the stage is in WAIT.

## Operation
- Decode is performed on instr_mem in IF using opcode [31:26] and funct [5:0]:
  - J = 6'h02, JAL = 6'h03, BEQ = 6'h04, BNE = 6'h05, LW = 6'h23.
  - JR = opcode 6'h00 with funct 6'h08.
- The stage has two states, RUN and WAIT, plus a 2-bit wait counter cnt.
- RUN, stall = 0, on each edge:
  - instr_rf <= instr_mem, pc_plus4_rf <= pc_out+4, valid_rf <= 1.
  - J/JAL: pc_out <= {pc_plus4[31:28], instr_mem[25:0], 2'b00}, where pc_plus4 = pc_out+4. No bubble; stay in RUN.
  - BEQ/BNE: pc_out <= pc_out+4, cnt <= 2, go to WAIT.
  - JR: pc_out <= pc_out+4, cnt <= 1, go to WAIT.
  - LW: pc_out <= pc_out+4, cnt <= 1, go to WAIT. This gives one load-use bubble.
  - Anything else: pc_out <= pc_out+4; stay in RUN.
- WAIT, stall = 0, on each edge:
  - instr_rf <= 32'h0, valid_rf <= 0, pc_plus4_rf unchanged, pc_out held, cnt <= cnt-1.
  - When cnt == 1: go to RUN. If redirect_valid = 1 that cycle, pc_out <= redirect_target.
  - redirect_valid is ignored in RUN and whenever cnt != 1.
- stall = 1: no register changes, including when redirect_valid = 1. The redirect is honoured only on the cycle it arrives unstalled with cnt == 1. The upstream stage holds redirect_valid/target for as long as it is stalled.
- Priority: reset > stall > WAIT/RUN logic.
- PC arithmetic is 32-bit modulo 2^32; 32'hFFFF_FFFC + 4 wraps to 32'h0.
- Low two bits of redirect_target and of the jump target are passed through unmodified. Misalignment is not checked.

## Timing
- Reset (async assert): pc_out = RESET_PC, instr_rf = 0, pc_plus4_rf = 0, valid_rf = 0, bubble = 0, state = RUN, cnt = 0.
- The first edge after reset deassert latches the instruction at RESET_PC into instr_rf.
- Reset asserted mid-WAIT aborts the wait. Any pending redirect is discarded.
- Fetch latency: instruction at address A is in instr_rf one edge after pc_out = A.
- BEQ/BNE (edge 0 latches the branch):
  - Edges 1 and 2 write NOP.
  - EX asserts redirect_valid in the cycle before edge 2; edge 2 applies it.
  - The target is fetched in the cycle after edge 2 and appears in instr_rf at edge 3.
  - Penalty: 2 bubbles.
- JR and LW (edge 0 latches the instruction):
  - Edge 1 writes NOP. For JR, RF asserts redirect in the cycle before edge 1.
  - Penalty: 1 bubble. LW never redirects.
- J/JAL: 0 bubbles. The target is in instr_rf one edge after the jump.
- bubble is combinational from state (1 iff WAIT).
- All other outputs are registered.
- pc_out changes only on clk edges or reset.

## Test plan
- Reset with RESET_PC = 32'h100, then straight-line code of 4 ADDs:
  - instr_rf shows the words at 0x100, 0x104, 0x108, 0x10C on consecutive edges, valid_rf = 1.
  - pc_plus4_rf = 0x104, 0x108, 0x10C, 0x110.
- BEQ at 0x10, redirect_valid = 1 with target 0x40 in its EX cycle:
  - Exactly 2 NOPs (valid_rf = 0, bubble = 1).
  - Next valid instr_rf is the word at 0x40.
  - Repeat with redirect_valid = 0: next valid instruction is the word at 0x14.
- JAL at 0x20 with addr field 0x0000010:
  - Next edge pc_out = 0x40, no bubble.
  - pc_plus4_rf = 0x24 while the JAL sits in RF.
- JR at 0x30 with redirect target 0x80 during its RF cycle:
  - 1 NOP, then the word at 0x80.
  - LW at 0x30: 1 NOP, then the word at 0x34.
- stall = 1 for 3 cycles during the second BEQ bubble, redirect_valid held with target 0x60:
  - All outputs frozen while stalled.
  - After release, 1 more NOP, then the word at 0x60.
- Reset asserted mid-WAIT, redirect_valid = 1 at the same time:
  - Outputs return to reset values immediately (no edge needed).
  - Fetch resumes at RESET_PC; the redirect is never applied.
  - pc_out = 32'hFFFF_FFFC with a non-control instruction: next pc_out = 32'h0.
